pe_psum_accumulator: RTL and testbench

//  Sits directly downstream of the bit-brick PE. It accumulates the PE's registered,
//  pre-shifted signed partial products into one wide result per multiply/dot-product

---
 rtl/pe_psum_accumulator.sv | 156 +++++++++++++++
 tb/tb_pe_psum_accumulator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_psum_accumulator.sv
// pe_psum_accumulator
//  Accumulates the bit-brick PE's pre-shifted signed partial products into one
//  wide result per group (first/last framed beats). The finished result is held
//  on a valid/ready output port, and back-pressure is returned to the PE sequencer.
//
//  Handshake: a beat transfers on a cycle where i_in_valid & o_in_ready is high.
//  A result transfers on a cycle where o_out_valid & i_out_ready is high. A
//  producer must hold its payload stable until the transfer happens.
//
// Ports
//  i_clk, i_rst_n      clock, asynchronous active-low reset
//  i_clear             synchronous flush of partial and pending results
//  i_in_valid/o_in_ready, i_prod, i_first, i_last   partial-product input beat
//  o_out_valid/i_out_ready, o_sum, o_ovf, o_count   group result
//  o_state             current FSM state (0 idle, 1 accum, 2 hold), debug only
module pe_psum_accumulator #(
  parameter int IN_W   = 21,
  parameter int ACC_W  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_prod,
  input  logic             i_first,
  input  logic             i_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf,
  output logic [7:0]       o_count,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int EXT_W = ACC_W + 1 - IN_W;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_count;
  logic             r_ovf;

  state_t           w_next_state;
  logic [ACC_W-1:0] w_next_acc;
  logic [7:0]       w_next_count;
  logic             w_next_ovf;

  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_acc_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_sum_ovf;
  logic [ACC_W-1:0] w_sum_fixed;
  logic [ACC_W-1:0] w_load;
  logic [7:0]       w_count_inc;
  logic             w_accept;

  // One guard bit above the accumulator: the top two bits of the sum disagree
  // exactly when the true result does not fit in ACC_W signed bits.
  assign w_prod_ext = {{EXT_W{i_prod[IN_W-1]}}, i_prod};
  assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
  assign w_sum      = w_acc_ext + w_prod_ext;
  assign w_sum_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_load     = w_prod_ext[ACC_W-1:0];

  // The guard bit carries the true sign, so it picks the clamp direction.
  always_comb begin
    w_sum_fixed = w_sum[ACC_W-1:0];
    if (w_sum_ovf && SAT_EN) begin
      w_sum_fixed = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  assign o_out_valid = (r_state == S_HOLD);
  assign o_in_ready  = ~o_out_valid | i_out_ready;
  assign w_accept    = i_in_valid & o_in_ready;

  assign o_sum   = r_acc;
  assign o_ovf   = r_ovf;
  assign o_count = r_count;
  assign o_state = r_state;

  always_comb begin
    w_next_state = r_state;
    w_next_acc   = r_acc;
    w_next_count = r_count;
    w_next_ovf   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_acc   = w_load;
          w_next_count = 8'd1;
          w_next_ovf   = 1'b0;
          w_next_state = i_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          if (i_first) begin
            w_next_acc   = w_load;
            w_next_count = 8'd1;
            w_next_ovf   = 1'b0;
          end else begin
            w_next_acc   = w_sum_fixed;
            w_next_count = w_count_inc;
            w_next_ovf   = r_ovf | w_sum_ovf;
          end
          w_next_state = i_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        // A beat arriving as the result drains opens the next group directly.
        if (i_out_ready) begin
          if (i_in_valid) begin
            w_next_acc   = w_load;
            w_next_count = 8'd1;
            w_next_ovf   = 1'b0;
            w_next_state = i_last ? S_HOLD : S_ACCUM;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_next_acc;
      r_count <= w_next_count;
      r_ovf   <= w_next_ovf;
    end
  end

endmodule

// File: tb/tb_pe_psum_accumulator.sv
module tb_pe_psum_accumulator;

  localparam int EXP_W = 41;  // {ovf, count[7:0], sum[31:0]}

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- main DUT (default parameters) ----------------
  logic        i_clear = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [20:0] i_prod = '0;
  logic        i_first = 1'b0;
  logic        i_last = 1'b0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [31:0] o_sum;
  logic        o_ovf;
  logic [7:0]  o_count;
  logic [1:0]  o_state;

  pe_psum_accumulator u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_prod(i_prod),
    .i_first(i_first), .i_last(i_last), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_sum(o_sum), .o_ovf(o_ovf),
    .o_count(o_count), .o_state(o_state)
  );

  // ---------------- narrow accumulators: saturating and wrapping ----------------
  logic        n_valid = 1'b0;
  logic [20:0] n_prod = '0;
  logic        n_first = 1'b0;
  logic        n_last = 1'b0;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [21:0] s_sum;
  logic [7:0]  s_count;
  logic [1:0]  s_state;
  logic        w_in_ready, w_out_valid, w_ovf;
  logic [21:0] w_sum;
  logic [7:0]  w_count;
  logic [1:0]  w_state;

  pe_psum_accumulator #(.IN_W(21), .ACC_W(22), .SAT_EN(1'b1)) u_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(1'b0),
    .i_in_valid(n_valid), .o_in_ready(s_in_ready), .i_prod(n_prod),
    .i_first(n_first), .i_last(n_last), .o_out_valid(s_out_valid),
    .i_out_ready(1'b1), .o_sum(s_sum), .o_ovf(s_ovf),
    .o_count(s_count), .o_state(s_state)
  );

  pe_psum_accumulator #(.IN_W(21), .ACC_W(22), .SAT_EN(1'b0)) u_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(1'b0),
    .i_in_valid(n_valid), .o_in_ready(w_in_ready), .i_prod(n_prod),
    .i_first(n_first), .i_last(n_last), .o_out_valid(w_out_valid),
    .i_out_ready(1'b1), .o_sum(w_sum), .o_ovf(w_ovf),
    .o_count(w_count), .o_state(w_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  bit     m_active = 1'b0;

  function automatic void model_beat(input longint p, input bit f, input bit l);
    longint s;
    logic [EXP_W-1:0] e;
    if (!m_active || f) begin
      m_acc = p;
      m_cnt = 1;
      m_ovf = 1'b0;
    end else begin
      s = m_acc + p;
      if (s > 64'sd2147483647) begin
        s = 64'sd2147483647;
        m_ovf = 1'b1;
      end else if (s < -64'sd2147483648) begin
        s = -64'sd2147483648;
        m_ovf = 1'b1;
      end
      m_acc = s;
      if (m_cnt < 255) m_cnt++;
    end
    if (l) begin
      e = {m_ovf, 8'(m_cnt), 32'(m_acc)};
      exp_q.push_back(e);
      m_active = 1'b0;
    end else begin
      m_active = 1'b1;
    end
  endfunction

  // Results are compared as they are handed over.
  always @(negedge i_clk) begin
    logic [EXP_W-1:0] e;
    logic [31:0] e_sum;
    if (o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", longint'(o_out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        e_sum = e[31:0];
        check("sum", longint'($signed(o_sum)), longint'($signed(e_sum)));
        check("count", longint'(o_count), longint'(e[39:32]));
        check("ovf", longint'(o_ovf), longint'(e[40]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input longint p, input bit f, input bit l);
    logic [63:0] pv;
    bit ok;
    int waited;
    pv = p;
    waited = 0;
    i_in_valid = 1'b1;
    i_prod = pv[20:0];
    i_first = f;
    i_last = l;
    forever begin
      @(negedge i_clk);
      ok = o_in_ready;
      @(posedge i_clk);
      if (ok) break;
      waited++;
      if (waited > 50) break;
      #1 i_out_ready = 1'b1;
    end
    if (ok) model_beat(p, f, l);
    else check("accept_timeout", 0, 1);
    #1;
    i_in_valid = 1'b0;
    i_first = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  longint rp;
  int glen;

  initial begin
    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_out_valid", longint'(o_out_valid), 0);
    check("rst_in_ready", longint'(o_in_ready), 1);
    check("rst_sum", longint'(o_sum), 0);
    check("rst_count", longint'(o_count), 0);
    check("rst_ovf", longint'(o_ovf), 0);
    i_rst_n = 1'b1;
    next_cycle();

    // overflow: 3 x 1048575 into a 22-bit accumulator
    n_valid = 1'b1;
    n_prod = 21'd1048575;
    n_first = 1'b1;
    next_cycle();
    n_first = 1'b0;
    next_cycle();
    n_last = 1'b1;
    next_cycle();
    n_valid = 1'b0;
    n_last = 1'b0;
    @(negedge i_clk);
    check("sat_valid", longint'(s_out_valid), 1);
    check("sat_sum", longint'($signed(s_sum)), 2097151);
    check("sat_ovf", longint'(s_ovf), 1);
    check("sat_count", longint'(s_count), 3);
    check("wrap_valid", longint'(w_out_valid), 1);
    check("wrap_sum", longint'($signed(w_sum)), -1048579);
    check("wrap_ovf", longint'(w_ovf), 1);
    next_cycle();

    // basic group, result the cycle after the last beat
    send_beat(100, 1, 0);
    send_beat(-30, 0, 0);
    send_beat(4096, 0, 1);
    @(negedge i_clk);
    check("latency_valid", longint'(o_out_valid), 1);
    check("latency_sum", longint'($signed(o_sum)), 4166);
    next_cycle();
    next_cycle();

    // back-pressure: pending result, beats offered but not absorbed
    i_out_ready = 1'b0;
    send_beat(7, 1, 0);
    send_beat(8, 0, 1);
    i_in_valid = 1'b1;
    i_prod = 21'd99;
    i_first = 1'b1;
    i_last = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      check("bp_in_ready", longint'(o_in_ready), 0);
      check("bp_valid", longint'(o_out_valid), 1);
      check("bp_sum", longint'($signed(o_sum)), 15);
      check("bp_count", longint'(o_count), 2);
    end
    next_cycle();
    i_in_valid = 1'b0;
    i_first = 1'b0;
    i_last = 1'b0;
    i_out_ready = 1'b1;
    next_cycle();
    next_cycle();

    // drain and new single-beat group in the same cycle
    i_out_ready = 1'b0;
    send_beat(1, 1, 0);
    send_beat(2, 0, 1);
    i_out_ready = 1'b1;
    send_beat(-7, 1, 1);
    @(negedge i_clk);
    check("b2b_valid", longint'(o_out_valid), 1);
    check("b2b_sum", longint'($signed(o_sum)), -7);
    check("b2b_count", longint'(o_count), 1);
    next_cycle();
    next_cycle();

    // restart mid-group on i_first
    send_beat(50, 1, 0);
    send_beat(60, 0, 0);
    send_beat(5, 1, 0);
    send_beat(6, 0, 1);
    next_cycle();
    next_cycle();

    // count saturation over a long group
    for (int i = 0; i < 300; i++) begin
      rp = longint'($urandom_range(0, 2097151)) - 1048576;
      send_beat(rp, i == 0, i == 299);
    end
    next_cycle();
    next_cycle();

    // random groups with random output back-pressure
    for (int g = 0; g < 25; g++) begin
      glen = $urandom_range(1, 5);
      for (int b = 0; b < glen; b++) begin
        i_out_ready = 1'($urandom_range(0, 1));
        rp = longint'($urandom_range(0, 2097151)) - 1048576;
        send_beat(rp, b == 0, b == glen - 1);
      end
    end
    i_out_ready = 1'b1;
    repeat (4) next_cycle();
    check("drain_empty", longint'(exp_q.size()), 0);

    // asynchronous reset while a result is held
    i_out_ready = 1'b0;
    send_beat(5, 1, 1);
    void'(exp_q.pop_back());
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", longint'(o_out_valid), 0);
    check("arst_sum", longint'(o_sum), 0);
    check("arst_count", longint'(o_count), 0);
    check("arst_ovf", longint'(o_ovf), 0);
    check("arst_in_ready", longint'(o_in_ready), 1);
    next_cycle();
    i_rst_n = 1'b1;
    i_out_ready = 1'b1;
    m_active = 1'b0;
    next_cycle();
    send_beat(9, 0, 1);
    next_cycle();
    next_cycle();

    // synchronous clear mid-group
    send_beat(100, 1, 0);
    i_clear = 1'b1;
    next_cycle();
    i_clear = 1'b0;
    m_active = 1'b0;
    check("clr_sum", longint'(o_sum), 0);
    check("clr_count", longint'(o_count), 0);
    check("clr_valid", longint'(o_out_valid), 0);
    check("clr_in_ready", longint'(o_in_ready), 1);
    send_beat(3, 0, 1);
    repeat (3) next_cycle();
    check("final_empty", longint'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
